// File: rtl/rd_ws_if.sv
// Read handshake between an initiator (rd/ds) and a target (ws/rvalid/rdata).
interface rd_ws_if #(
  parameter int DW = 8
);
  logic          rd;
  logic          ds;
  logic          ws;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output rd,
    output ds,
    input  ws,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  rd,
    input  ds,
    output ws,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/rd_ws_responder.sv
// Target-side responder for the rd/ws/ds read handshake: inserts a
// programmable number of wait states, then presents data from a small local
// store until the initiator's done strobe, advancing the read pointer and
// counting completed transfers.
module rd_ws_responder #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int WW = 4
) (
  input  logic          clk,
  input  logic          rst,
  rd_ws_if.slave        bus,
  input  logic [WW-1:0] wait_cfg,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [AW-1:0] addr,
  output logic [15:0]   xfer_cnt,
  output logic          abort
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] cnt, cnt_nxt;
  logic          load_rdata;
  logic          done;
  logic          abort_nxt;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] store [2**AW];

  // Handshake outputs decode straight from the registered state.
  assign bus.ws     = (state == WAIT);
  assign bus.rvalid = (state == READY);
  assign bus.rdata  = rdata_q;

  // State and wait-state counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; ds only matters in READY and READY wins over rd.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_rdata = 1'b0;
    done       = 1'b0;
    abort_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd) begin
          if (wait_cfg == '0) begin
            state_nxt  = READY;
            load_rdata = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = wait_cfg;
          end
        end
      end
      WAIT: begin
        if (!bus.rd) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else if (cnt > WW'(1)) begin
          cnt_nxt = cnt - WW'(1);
        end else begin
          state_nxt  = READY;
          load_rdata = 1'b1;
        end
      end
      READY: begin
        if (bus.ds) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data capture, pointer/count advance on completion, abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      addr     <= '0;
      xfer_cnt <= '0;
      abort    <= 1'b0;
    end else begin
      abort <= abort_nxt;
      if (load_rdata) begin
        rdata_q <= store[addr];
      end
      if (done) begin
        addr     <= addr + AW'(1);
        xfer_cnt <= xfer_cnt + 16'd1;
      end
    end
  end

  // Local store write port; a same-edge read sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      store[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_rd_ws_responder.sv
// Bench for rd_ws_responder: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_rd_ws_responder;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WW-1:0] wait_cfg = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] addr;
  logic [15:0]   xfer_cnt;
  logic          abort;

  rd_ws_if #(.DW(DW)) bus ();

  rd_ws_responder #(.DW(DW), .AW(AW), .WW(WW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wait_cfg (wait_cfg),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .addr     (addr),
    .xfer_cnt (xfer_cnt),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ws_cycles = 0;
  int ab_cycles = 0;

  logic [7:0] pre [16];

  // Reference model: a transfer is "busy" from its start; it spends cfg
  // cycles waiting, then shows data until ds.
  bit         m_busy = 1'b0;
  int         m_elapsed = 0;
  int         m_cfg = 0;
  logic [7:0] m_rdata = '0;
  logic [3:0] m_addr = '0;
  logic [15:0] m_cnt = '0;
  bit         m_abort = 1'b0;
  logic [7:0] mem [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_abort = 1'b0;
    if (!m_busy) begin
      if (bus.rd) begin
        m_busy    = 1'b1;
        m_cfg     = int'(wait_cfg);
        m_elapsed = 0;
        if (m_cfg == 0) m_rdata = mem[m_addr];
      end
    end else if (m_elapsed < m_cfg) begin
      if (!bus.rd) begin
        m_busy  = 1'b0;
        m_abort = 1'b1;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_cfg) m_rdata = mem[m_addr];
      end
    end else if (bus.ds) begin
      m_busy = 1'b0;
      m_addr = m_addr + 4'd1;
      m_cnt  = m_cnt + 16'd1;
    end
    if (wr_en) mem[wr_addr] = wr_data;
  endtask

  // Model update and full output comparison after every edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_elapsed = 0; m_cfg = 0; m_rdata = '0;
      m_addr = '0; m_cnt = '0; m_abort = 1'b0;
    end else begin
      model_step();
    end
    #1;
    chk("ws",       32'(bus.ws),     32'(m_busy && m_elapsed < m_cfg));
    chk("rvalid",   32'(bus.rvalid), 32'(m_busy && m_elapsed >= m_cfg));
    chk("rdata",    32'(bus.rdata),  32'(m_rdata));
    chk("addr",     32'(addr),       32'(m_addr));
    chk("xfer_cnt", 32'(xfer_cnt),   32'(m_cnt));
    chk("abort",    32'(abort),      32'(m_abort));
  end

  task automatic step();
    @(negedge clk);
    if (bus.ws) ws_cycles++;
    if (abort) ab_cycles++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ws"},     32'(bus.ws),     32'd0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    chk({tag, "_rdata"},  32'(bus.rdata),  32'd0);
    chk({tag, "_addr"},   32'(addr),       32'd0);
    chk({tag, "_xfer"},   32'(xfer_cnt),   32'd0);
    chk({tag, "_abort"},  32'(abort),      32'd0);
  endtask

  // One complete transfer; wait_cfg is scrambled after start to show it is
  // ignored mid-transfer.
  task automatic xfer(input int cfg, input bit rd_with_ds, output logic [7:0] got);
    int n;
    wait_cfg = WW'(cfg);
    bus.rd = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      wait_cfg = WW'($urandom_range(0, 15));
    end while (!bus.rvalid && n < 40);
    chk("latency", 32'(n), 32'(cfg + 1));
    got = bus.rdata;
    bus.rd = rd_with_ds;
    bus.ds = 1'b1;
    step();
    bus.ds = 1'b0;
    bus.rd = 1'b0;
  endtask

  initial begin
    logic [7:0] got;
    bus.rd = 1'b0;
    bus.ds = 1'b0;
    for (int i = 0; i < 16; i++) pre[i] = 8'($urandom_range(0, 255));
    pre[0] = 8'hA5;
    pre[1] = 8'h3C;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;

    // Preload the store
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = pre[i];
      step();
    end
    wr_en = 1'b0;

    // Zero wait states, rd held two cycles
    ws_cycles = 0;
    wait_cfg = '0;
    bus.rd = 1'b1;
    step();
    chk("t1_rvalid", 32'(bus.rvalid), 32'd1);
    chk("t1_rdata",  32'(bus.rdata),  32'hA5);
    step();
    bus.rd = 1'b0; bus.ds = 1'b1;
    step();
    bus.ds = 1'b0;
    chk("t1_ws_cycles", 32'(ws_cycles), 32'd0);
    chk("t1_addr",      32'(addr),      32'd1);
    chk("t1_xfer",      32'(xfer_cnt),  32'd1);
    chk("t1_rdata_hold", 32'(bus.rdata), 32'hA5);

    // Three wait states
    ws_cycles = 0;
    xfer(3, 1'b0, got);
    chk("t2_ws_cycles", 32'(ws_cycles), 32'd3);
    chk("t2_rdata",     32'(got),       32'h3C);
    chk("t2_addr",      32'(addr),      32'd2);

    // Abort during wait
    ws_cycles = 0; ab_cycles = 0;
    wait_cfg = WW'(5);
    bus.rd = 1'b1;
    step();
    step();
    bus.rd = 1'b0;
    step();
    step();
    chk("t3_abort_cycles", 32'(ab_cycles), 32'd1);
    chk("t3_ws_cycles",    32'(ws_cycles), 32'd2);
    chk("t3_ws",           32'(bus.ws),    32'd0);
    chk("t3_addr",         32'(addr),      32'd2);
    chk("t3_xfer",         32'(xfer_cnt),  32'd2);
    xfer(1, 1'b0, got);
    chk("t3_same_addr", 32'(got), 32'(pre[2]));

    // 17 back-to-back transfers from reset, wrapping the pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      xfer($urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
      chk("t4_rdata", 32'(got), 32'(pre[i % 16]));
    end
    chk("t4_addr", 32'(addr),     32'd1);
    chk("t4_xfer", 32'(xfer_cnt), 32'd17);

    // Write on the READY-entry edge is read-first
    wait_cfg = WW'(2);
    bus.rd = 1'b1;
    step();
    step();
    wr_en = 1'b1; wr_addr = addr; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    chk("t5_rvalid", 32'(bus.rvalid), 32'd1);
    chk("t5_old",    32'(bus.rdata),  32'h3C);
    bus.rd = 1'b0; bus.ds = 1'b1;
    step();
    bus.ds = 1'b0;
    for (int i = 0; i < 15; i++) xfer($urandom_range(0, 2), 1'b0, got);
    chk("t5_addr_wrap", 32'(addr), 32'd1);
    xfer(0, 1'b0, got);
    chk("t5_new", 32'(got), 32'h77);

    // Asynchronous reset during WAIT
    wait_cfg = WW'(4);
    bus.rd = 1'b1;
    step();
    step();
    #3 rst = 1'b1;
    #1 check_zero("t6_wait");
    bus.rd = 1'b0;
    step();
    rst = 1'b0;

    // Asynchronous reset during READY
    wait_cfg = '0;
    bus.rd = 1'b1;
    step();
    chk("t6_ready_rvalid", 32'(bus.rvalid), 32'd1);
    #3 rst = 1'b1;
    #1 check_zero("t6_ready");
    bus.rd = 1'b0;
    step();
    rst = 1'b0;
    xfer(0, 1'b0, got);
    chk("t6_clean_rdata", 32'(got),      32'hA5);
    chk("t6_clean_addr",  32'(addr),     32'd1);
    chk("t6_clean_xfer",  32'(xfer_cnt), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.rd   = ($urandom_range(0, 3) != 0);
      bus.ds   = ($urandom_range(0, 2) == 0);
      wait_cfg = WW'($urandom_range(0, 6));
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = AW'($urandom_range(0, 15));
      wr_data  = 8'($urandom_range(0, 255));
      step();
    end
    wr_en = 1'b0; bus.rd = 1'b0; bus.ds = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
